// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated bank of SR flag bits shared by NREQ requesters.
// Optional macro SR_FLAG_TOGGLE_EN turns command 11 into a toggle (JK semantics).
module sr_flag_arbiter #(
    parameter int NREQ   = 4,
    parameter int NFLAG  = 8,
    parameter int FIDX_W = 3,
    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_s,
    input  logic [NREQ-1:0]          req_r,
    input  logic [NREQ*FIDX_W-1:0]   req_idx,
    input  logic                     err_clr,
    output logic [NREQ-1:0]          gnt,
    output logic [NFLAG-1:0]         flags,
    output logic                     busy,
    output logic                     err,
    output logic [IW-1:0]            err_id
);

    typedef enum logic {IDLE, APPLY} state_t;

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       win;
    logic                lat_s;
    logic                lat_r;
    logic [FIDX_W-1:0]   lat_idx;

    logic                found;
    logic [IW-1:0]       win_c;
    logic [NFLAG:0]      apply_res;

    // Returns {error, next flag bank} for one latched command.
    function automatic logic [NFLAG:0] apply_cmd(input logic [NFLAG-1:0] cur,
                                                 input logic s, input logic r,
                                                 input logic [FIDX_W-1:0] idx);
        logic [NFLAG-1:0] nf;
        logic             e;
        nf = cur;
        e  = 1'b0;
        if (32'(idx) >= NFLAG) begin
            e = 1'b1;
        end else begin
            for (int f = 0; f < NFLAG; f++) begin
                if (32'(idx) == f) begin
                    case ({s, r})
                        2'b10:   nf[f] = 1'b1;
                        2'b01:   nf[f] = 1'b0;
                        2'b11: begin
`ifdef SR_FLAG_TOGGLE_EN
                            nf[f] = ~cur[f];
`else
                            e = 1'b1;
`endif
                        end
                        default: nf[f] = cur[f];
                    endcase
                end
            end
        end
        return {e, nf};
    endfunction

    // Descending scan so the candidate closest to ptr is assigned last and wins.
    always_comb begin
        found = 1'b0;
        win_c = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int c;
            c = int'(ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            if (req[IW'(c)]) begin
                found = 1'b1;
                win_c = IW'(c);
            end
        end
    end

    assign apply_res = apply_cmd(flags, lat_s, lat_r, lat_idx);
    assign busy      = (state == APPLY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= '0;
            win    <= '0;
            gnt    <= '0;
            flags  <= '0;
            err    <= 1'b0;
            err_id <= '0;
        end else begin
            if (err_clr) begin
                err    <= 1'b0;
                err_id <= '0;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        win   <= win_c;
                        gnt   <= NREQ'(1) << win_c;
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    flags <= apply_res[NFLAG-1:0];
                    gnt   <= '0;
                    ptr   <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                    state <= IDLE;
                    // A fresh error beats a simultaneous clear.
                    if (apply_res[NFLAG] && (!err || err_clr)) begin
                        err    <= 1'b1;
                        err_id <= win;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command capture needs no reset: it is only consumed in APPLY.
    always_ff @(posedge clk) begin
        if (state == IDLE && found) begin
            lat_s   <= req_s[win_c];
            lat_r   <= req_r[win_c];
            lat_idx <= req_idx[int'(win_c)*FIDX_W +: FIDX_W];
        end
    end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shared bank of NFLAG synchronous SR flag bits, written by NREQ requesters through a round-robin arbiter.
- Each requester presents a set/reset command and a flag index; the arbiter grants one requester per transaction and applies SR semantics to the addressed flag.
- Sits between control agents and the SR status flags they share; replaces per-agent SR flip-flops with one arbitrated bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NFLAG, 8, number of SR flag bits in the bank.
- FIDX_W, 3, flag index width; must satisfy 2**FIDX_W >= NFLAG.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  NREQ  per-requester request; held high until its gnt bit is seen.
- req_s  input  NREQ  per-requester set command bit.
- req_r  input  NREQ  per-requester reset command bit.
- req_idx  input  NREQ*FIDX_W  per-requester flag index; requester i uses bits [i*FIDX_W +: FIDX_W].
- err_clr  input  1  synchronous clear of err and err_id.
- gnt  output  NREQ  registered one-hot grant, one-cycle pulse.
- flags  output  NFLAG  flag bank contents.
- busy  output  1  high while state = APPLY.
- err  output  1  sticky error flag.
- err_id  output  clog2(NREQ)  requester that caused the first unserviced error.

Behaviour:
- Reset (reset=0, any time, including mid-transaction):
  - state=IDLE; gnt=0, flags=0, busy=0, err=0, err_id=0.
  - Round-robin pointer ptr=0; any latched command is discarded.
- FSM has two states, IDLE and APPLY.
- IDLE:
  - If any req bit is high, pick the winner by searching ptr, ptr+1, ... mod NREQ; the first set bit wins.
  - Latch the winner's s, r and idx; set gnt[winner]=1; go to APPLY.
  - If no req bit is high, stay in IDLE with gnt=0.
- APPLY (exactly one cycle; gnt and busy are high throughout):
  - At the closing edge, update the addressed flag, set gnt=0, set ptr=(winner+1) mod NREQ, go to IDLE.
  - No arbitration happens in APPLY. Peak throughput is one transaction per 2 cycles.
- Latency: req sampled high at edge N -> gnt high after edge N -> flag updated at edge N+1.
- Handshake:
  - The requester drops req, or presents a new command, at the edge that ends its gnt cycle.
  - req still high in the following IDLE cycle counts as a new request.
- Command decode on latched (s, r):
  - 10 sets the flag to 1.
  - 01 clears the flag to 0.
  - 00 holds the flag; this is still a granted transaction.
  - 11 is invalid: flag unchanged, err set.
- Index decode: idx >= NFLAG is out of range. No flag changes and err is set, regardless of the command.
- Error capture:
  - err is sticky. err_id loads only when err goes 0 -> 1; later errors do not overwrite it.
  - err_clr=1 clears err and err_id at the next edge.
  - If err_clr coincides with a new error in the same APPLY cycle, the new error wins: err=1, err_id=new requester.
- Command inputs of non-granted requesters are ignored; only latched values are used in APPLY.
- Stable inputs during APPLY are not required; latching happens at the IDLE->APPLY edge.

Optional Feature:
- Macro: SR_FLAG_TOGGLE_EN.
- Defined: latched command 11 toggles the addressed in-range flag (JK semantics) and does not set err. An out-of-range idx still sets err.
- Undefined: 11 is invalid as described in Behaviour.

Test Plan:
- Reset/set/clear: reset=0 for 2 cycles, then 1. Requester 0 issues s=1,r=0,idx=3 -> gnt=0001 after the first edge, flags=0x08 after the second edge. Then s=0,r=1,idx=3 -> flags=0x00.
- Round-robin: req=1111 held continuously, each granted requester setting flag i -> grant order 0001, 0010, 0100, 1000, 0001; gnt pulses every 2 cycles; flags=0x0F after 8 cycles.
- Fairness after grant: ptr=2, req=0011 -> gnt=0001 first, then 0010; requester 0 is not granted twice in a row while requester 1 is waiting.
- Error: requester 2 issues s=1,r=1,idx=5 -> flags unchanged, err=1, err_id=2. Then requester 1 issues idx=7 with NFLAG=6 -> err_id stays 2. Then err_clr=1 -> err=0, err_id=0.
- Reset mid-operation: reset=0 asserted during the APPLY cycle of a set to flag 1 -> gnt=0 and flags=0 immediately; after release, FSM is in IDLE with ptr=0.
- Toggle (SR_FLAG_TOGGLE_EN defined): s=1,r=1,idx=4 issued twice -> flags bit 4 goes 0 -> 1 -> 0, err stays 0.
